// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller and its benches.
package fetch_ctrl_pkg;

   // Controller state, exposed on fc_state for debug.
   typedef enum logic [2:0] {
      FC_BOOT  = 3'd0,
      FC_RUN   = 3'd1,
      FC_FLUSH = 3'd2,
      FC_HALT  = 3'd3
   } fc_state_t;

   // Decode-stage issue counts.
   localparam logic [1:0] ISSUE_NONE = 2'd0;
   localparam logic [1:0] ISSUE_ONE  = 2'd1;
   localparam logic [1:0] ISSUE_TWO  = 2'd2;

   // Fetch mode driven into IF; also used by the IF/ID bench.
   typedef enum logic [1:0] {
      FM_HOLD   = 2'd0,
      FM_SINGLE = 2'd1,
      FM_DUAL   = 2'd2
   } fetch_mode_t;

   // Instruction words fetched for a given mode.
   function automatic logic [1:0] fetch_words(input fetch_mode_t mode);
      case (mode)
         FM_SINGLE: return 2'd1;
         FM_DUAL:   return 2'd2;
         default:   return 2'd0;
      endcase
   endfunction

   // An issue count of 3 behaves as 2.
   function automatic logic [1:0] issue_sat(input logic [1:0] ic);
      return (ic > ISSUE_TWO) ? ISSUE_TWO : ic;
   endfunction

endpackage

// File: rtl/fc_perf_counter.sv
// Wrapping performance accumulator with a 2-bit per-cycle increment.
module fc_perf_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [1:0]       inc,
   output logic [CNT_W-1:0] cnt
);

   // Accumulate; wraps naturally modulo 2^CNT_W.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) cnt <= '0;
      else        cnt <= cnt + CNT_W'(inc);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: boot hold, dual/single fetch, flush bubbles, debug halt.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES  = 4,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [1:0]       issue_count,
   input  logic             taken_branch1,
   input  logic             taken_branch2,
   input  logic             flush_req,
   input  logic             halt_req,
   output logic             single_fetch,
   output logic             fetchNull1,
   output logic             no_new_fetch,
   output logic             FREEZE,
   output logic             halt_ack,
   output logic [2:0]       fc_state,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned BOOT_W  = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES)  : 1;
   localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   fc_state_t          state, state_nxt;
   logic [BOOT_W-1:0]  boot_cnt, boot_cnt_nxt;
   logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nxt;

   fetch_mode_t mode;
   logic        null1;
   logic        freeze_c;
   logic        ack_c;
   logic        stall_c;
   logic        any_branch;

   assign any_branch = taken_branch1 | taken_branch2;

   // State and sequencing counters.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= FC_BOOT;
         boot_cnt  <= BOOT_W'(BOOT_CYCLES - 1);
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         boot_cnt  <= boot_cnt_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   // Next-state selection; branches win over flush, flush over halt.
   always_comb begin
      state_nxt     = state;
      boot_cnt_nxt  = boot_cnt;
      flush_cnt_nxt = flush_cnt;
      case (state)
         FC_BOOT: begin
            if (boot_cnt == '0) state_nxt    = FC_RUN;
            else                boot_cnt_nxt = boot_cnt - 1'b1;
         end
         FC_RUN: begin
            if (any_branch) begin
               state_nxt = FC_RUN;
            end else if (flush_req) begin
               if (FLUSH_CYCLES > 1) begin
                  state_nxt     = FC_FLUSH;
                  flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES - 1);
               end
            end else if (halt_req) begin
               state_nxt = FC_HALT;
            end
         end
         FC_FLUSH: begin
            if (any_branch) begin
               state_nxt = FC_RUN;
            end else if (flush_req) begin
               flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES - 1);
            end else if (flush_cnt == '0) begin
               state_nxt = FC_RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - 1'b1;
            end
         end
         FC_HALT: begin
            if (!halt_req) state_nxt = FC_RUN;
         end
         default: state_nxt = FC_BOOT;
      endcase
   end

   // Fetch mode and control decode from state and current inputs.
   always_comb begin
      mode     = FM_HOLD;
      null1    = 1'b0;
      freeze_c = 1'b0;
      ack_c    = 1'b0;
      case (state)
         FC_BOOT: begin
            mode  = FM_HOLD;
            null1 = 1'b1;
         end
         FC_RUN: begin
            if (any_branch) begin
               mode = FM_DUAL;
            end else if (flush_req) begin
               mode  = FM_DUAL;
               null1 = 1'b1;
            end else if (halt_req) begin
               mode     = FM_HOLD;
               freeze_c = 1'b1;
            end else begin
               case (issue_sat(issue_count))
                  ISSUE_NONE: mode = FM_HOLD;
                  ISSUE_ONE:  mode = FM_SINGLE;
                  default:    mode = FM_DUAL;
               endcase
            end
         end
         FC_FLUSH: begin
            mode  = FM_DUAL;
            null1 = 1'b1;
         end
         FC_HALT: begin
            mode     = FM_HOLD;
            freeze_c = 1'b1;
            ack_c    = 1'b1;
         end
         default: begin
            mode  = FM_HOLD;
            null1 = 1'b1;
         end
      endcase
   end

   assign stall_c      = (state == FC_RUN) && (mode == FM_HOLD);
   assign single_fetch = (mode == FM_SINGLE);
   assign no_new_fetch = (mode == FM_HOLD);
   assign fetchNull1   = null1;
   assign FREEZE       = freeze_c;
   assign halt_ack     = ack_c;
   assign fc_state     = state;

   fc_perf_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (fetch_words(mode)),
      .cnt   (fetch_cnt)
   );

   fc_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   ({1'b0, stall_c}),
      .cnt   (stall_cnt)
   );

endmodule
